life_step_ctrl: RTL and testbench

LIFE_STEP_CTRL -- requirements
Module: life_step_ctrl

---
 rtl/life_step_ctrl_if.sv | 27 ++
 rtl/life_step_ctrl.sv | 160 ++++++++++++++++
 tb/tb_life_step_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/life_step_ctrl_if.sv
// Control, display, host-load and frame-buffer signals of the life step engine.
// The engine sits on the slave side; the host/display/frame-buffer side is the master.
interface life_step_ctrl_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic        disp_req;
    logic [6:0]  disp_addr;
    logic        host_wr_en;
    logic [6:0]  host_wr_addr;
    logic [0:31] host_wr_data;
    logic [6:0]  fb_rd_addr;
    logic [0:31] fb_rd_data;
    logic        fb_wr_en;
    logic [6:0]  fb_wr_addr;
    logic [0:31] fb_wr_data;

    modport master (
        output start, disp_req, disp_addr, host_wr_en, host_wr_addr, host_wr_data, fb_rd_data,
        input  busy, done, gen_count, fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data
    );
    modport slave (
        input  start, disp_req, disp_addr, host_wr_en, host_wr_addr, host_wr_data, fb_rd_data,
        output busy, done, gen_count, fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data
    );
endinterface

// File: rtl/life_step_ctrl.sv
// In-place Conway B3/S23 generation step over a 75x32 toroidal frame buffer,
// using a three-row window plus a saved copy of original row 0 for the wrap.
module life_cell (
    input  logic [2:0] up,   // [2]=left col, [1]=own col, [0]=right col
    input  logic [2:0] mid,
    input  logic [2:0] dn,
    output logic       nxt
);
    logic [7:0] nb;
    logic [3:0] n;

    assign nb = {up, mid[2], mid[0], dn};

    always_comb begin
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, nb[i]};
    end

    assign nxt = (n == 4'd3) || (mid[1] && (n == 4'd2));
endmodule

module life_step_ctrl (
    input logic             clk,
    input logic             rst_n,
    life_step_ctrl_if.slave bus
);
    localparam int         NUM_LANES = 32;
    localparam logic [6:0] LAST_ROW  = 7'd74;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRIME     = 3'd1;
    localparam logic [2:0] ROW_CALC  = 3'd2;
    localparam logic [2:0] ROW_FETCH = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]             state;
    logic [6:0]             row;
    logic [1:0]             prime_iss;
    logic [1:0]             prime_cap;
    logic                   rd_pend;
    logic [6:0]             rd_addr_q;
    logic [15:0]            gen_cnt;
    logic [0:NUM_LANES-1]   prev_row, cur_row, next_row, wrap_row, calc_row;

    logic                   eng_rd, grant, eng_wr, host_wr;
    logic [6:0]             eng_addr;

    // In ROW_CALC the window centre is row r, so the fetch for r+2 is issued
    // alongside the write; ROW_FETCH only re-issues it when the display won.
    always_comb begin
        eng_rd   = 1'b0;
        eng_addr = '0;
        case (state)
            PRIME: begin
                eng_rd   = (prime_iss != 2'd3);
                eng_addr = (prime_iss == 2'd0) ? LAST_ROW :
                           (prime_iss == 2'd1) ? 7'd0 : 7'd1;
            end
            ROW_CALC: begin
                eng_rd   = (row < LAST_ROW - 7'd1);
                eng_addr = row + 7'd2;
            end
            ROW_FETCH: begin
                eng_rd   = !rd_pend;
                eng_addr = row + 7'd1;
            end
            default: ;
        endcase
    end

    assign grant   = eng_rd && !bus.disp_req;
    assign eng_wr  = (state == ROW_CALC);
    assign host_wr = (state == IDLE) && bus.host_wr_en;

    assign bus.fb_rd_addr = !rst_n       ? 7'd0          :
                            bus.disp_req ? bus.disp_addr :
                            grant        ? eng_addr      : rd_addr_q;

    assign bus.fb_wr_en   = rst_n && (eng_wr || host_wr);
    assign bus.fb_wr_addr = !rst_n ? 7'd0 : eng_wr ? row      : host_wr ? bus.host_wr_addr : 7'd0;
    assign bus.fb_wr_data = !rst_n ? '0   : eng_wr ? calc_row : host_wr ? bus.host_wr_data : '0;

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.gen_count = gen_cnt;

    for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
        localparam int L = (c + NUM_LANES - 1) % NUM_LANES;
        localparam int R = (c + 1) % NUM_LANES;
        life_cell u_cell (
            .up  ({prev_row[L], prev_row[c], prev_row[R]}),
            .mid ({cur_row[L],  cur_row[c],  cur_row[R]}),
            .dn  ({next_row[L], next_row[c], next_row[R]}),
            .nxt (calc_row[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            prime_iss <= '0;
            prime_cap <= '0;
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
            gen_cnt   <= '0;
            prev_row  <= '0;
            cur_row   <= '0;
            next_row  <= '0;
            wrap_row  <= '0;
        end else begin
            rd_addr_q <= bus.fb_rd_addr;
            rd_pend   <= grant;
            case (state)
                IDLE: if (bus.start) begin
                    state     <= PRIME;
                    row       <= '0;
                    prime_iss <= '0;
                    prime_cap <= '0;
                end
                PRIME: begin
                    if (grant) prime_iss <= prime_iss + 2'd1;
                    if (rd_pend) begin
                        prime_cap <= prime_cap + 2'd1;
                        case (prime_cap)
                            2'd0: prev_row <= bus.fb_rd_data;
                            2'd1: begin
                                cur_row  <= bus.fb_rd_data;
                                wrap_row <= bus.fb_rd_data;
                            end
                            default: begin
                                next_row <= bus.fb_rd_data;
                                state    <= ROW_CALC;
                            end
                        endcase
                    end
                end
                ROW_CALC: begin
                    prev_row <= cur_row;
                    cur_row  <= next_row;
                    if (row == LAST_ROW) begin
                        state   <= DONE;
                        gen_cnt <= gen_cnt + 16'd1;
                    end else begin
                        row <= row + 7'd1;
                        // Row 74's lower neighbour is original row 0, already overwritten in the buffer.
                        if (row == LAST_ROW - 7'd1) next_row <= wrap_row;
                        else                        state    <= ROW_FETCH;
                    end
                end
                ROW_FETCH: if (rd_pend) begin
                    next_row <= bus.fb_rd_data;
                    state    <= ROW_CALC;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_step_ctrl.sv
// Randomized bench for life_step_ctrl: owns the frame buffer and a 2-D Life model.
module tb_life_step_ctrl;
    logic clk, rst_n;
    life_step_ctrl_if bus();

    life_step_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:31] mem    [75];
    logic [0:31] exp_fb [75];
    logic [0:31] nxt_fb [75];
    int n_vec = 0, n_err = 0;
    int gen_exp = 0;

    // frame buffer: registered read, synchronous write
    always @(posedge clk) begin
        bus.fb_rd_data <= (bus.fb_rd_addr < 7'd75) ? mem[bus.fb_rd_addr] : '0;
        if (bus.fb_wr_en && bus.fb_wr_addr < 7'd75) mem[bus.fb_wr_addr] <= bus.fb_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // plain 2-D Life on the torus
    task automatic calc_next();
        for (int r = 0; r < 75; r++)
            for (int c = 0; c < 32; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(exp_fb[(r + dr + 75) % 75][(c + dc + 32) % 32]);
                nxt_fb[r][c] = (n == 3) || (exp_fb[r][c] && n == 2);
            end
    endtask

    task automatic host_write(input logic [6:0] a, input logic [0:31] d);
        @(negedge clk);
        bus.host_wr_en = 1'b1; bus.host_wr_addr = a; bus.host_wr_data = d;
        #1;
        chk("host_en", 32'(bus.fb_wr_en), 32'd1);
        chk("host_addr", 32'(bus.fb_wr_addr), 32'(a));
        chk("host_data", bus.fb_wr_data, d);
        @(posedge clk); #1;
        bus.host_wr_en = 1'b0;
    endtask

    task automatic load_frame();
        for (int r = 0; r < 75; r++) host_write(7'(r), exp_fb[r]);
    endtask

    task automatic chk_frame(input string tag);
        for (int r = 0; r < 75; r++) chk(tag, mem[r], exp_fb[r]);
    endtask

    task automatic set_glider(input int br, input int bc);
        int cells[5][2] = '{'{0,1}, '{1,2}, '{2,0}, '{2,1}, '{2,2}};
        for (int r = 0; r < 75; r++) exp_fb[r] = '0;
        for (int k = 0; k < 5; k++)
            exp_fb[(br + cells[k][0]) % 75][(bc + cells[k][1]) % 32] = 1'b1;
    endtask

    // One generation; contend randomizes display traffic, poke injects start/host write while busy.
    task automatic do_step(input bit contend, input bit poke);
        int wr_n = 0, cyc = 1, lat = 0;
        bit seen = 0;
        calc_next();
        @(negedge clk);
        bus.start = 1'b1;
        #1 chk("idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        while (!seen && cyc < 600) begin
            bus.disp_req  = contend ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.disp_addr = 7'($urandom_range(0, 127));
            if (poke && (cyc == 50 || cyc == 51)) begin
                bus.start = 1'b1; bus.host_wr_en = 1'b1;
                bus.host_wr_addr = 7'd5; bus.host_wr_data = '1;
            end else begin
                bus.start = 1'b0; bus.host_wr_en = 1'b0;
            end
            #1;
            if (cyc == 1) chk("busy_after_start", 32'(bus.busy), 32'd1);
            if (bus.disp_req) chk("rd_prio", 32'(bus.fb_rd_addr), 32'(bus.disp_addr));
            if (bus.fb_wr_en) begin
                chk("wr_addr", 32'(bus.fb_wr_addr), 32'(wr_n));
                chk("wr_data", bus.fb_wr_data, nxt_fb[wr_n % 75]);
                wr_n++;
            end
            if (bus.done) begin
                seen = 1;
                lat  = cyc;
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        bus.disp_req = 1'b0; bus.start = 1'b0; bus.host_wr_en = 1'b0;
        gen_exp++;
        chk("done_seen", 32'(seen), 32'd1);
        chk("wr_count", 32'(wr_n), 32'd75);
        if (!contend) chk("latency_le_160", 32'(lat <= 160), 32'd1);
        #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("gen_count", 32'(bus.gen_count), 32'(gen_exp));
        for (int r = 0; r < 75; r++) exp_fb[r] = nxt_fb[r];
        repeat (3) @(negedge clk);
        #1 chk("idle_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.host_wr_en = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        bus.disp_req = 1'b1; bus.disp_addr = 7'd33;
        for (int r = 0; r < 75; r++) mem[r] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_gen", 32'(bus.gen_count), 32'd0);
        chk("rst_wr_en", 32'(bus.fb_wr_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.fb_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(bus.fb_wr_addr), 32'd0);
        chk("rst_wr_data", bus.fb_wr_data, 32'd0);
        @(negedge clk);
        bus.disp_req = 1'b0;
        rst_n = 1'b1;

        // blinker
        for (int r = 0; r < 75; r++) exp_fb[r] = '0;
        exp_fb[10] = 32'h00E0_0000;
        load_frame();
        do_step(1'b0, 1'b0);
        chk("blink_r9",  mem[9],  32'h0040_0000);
        chk("blink_r10", mem[10], 32'h0040_0000);
        chk("blink_r11", mem[11], 32'h0040_0000);
        chk("blink_r12", mem[12], 32'h0);
        chk_frame("blink_frame");

        // all-zero frame with start and host write poked while busy
        for (int r = 0; r < 75; r++) exp_fb[r] = '0;
        load_frame();
        do_step(1'b0, 1'b1);
        chk_frame("zero_frame");
        host_write(7'd5, 32'hDEAD_BEEF);
        chk("idle_host_mem", mem[5], 32'hDEAD_BEEF);

        // glider across both seams, four contended steps -> shifted by (1,1)
        set_glider(73, 30);
        load_frame();
        repeat (4) do_step(1'b1, 1'b0);
        set_glider(74, 31);
        chk_frame("glider_frame");

        // random frames under display contention
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 75; r++) exp_fb[r] = $urandom();
            load_frame();
            do_step(1'b1, 1'b0);
            chk_frame("rand_frame");
        end

        // reset while row 40 is being written
        for (int r = 0; r < 75; r++) exp_fb[r] = $urandom();
        load_frame();
        calc_next();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            #1;
            if (bus.fb_wr_en && bus.fb_wr_addr == 7'd40) found = 1;
            else @(negedge clk);
        end
        chk("rst_row40_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(bus.fb_wr_en), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_gen", 32'(bus.gen_count), 32'd0);
        chk("mid_rst_rd_addr", 32'(bus.fb_rd_addr), 32'd0);
        chk("mid_rst_wr_addr", 32'(bus.fb_wr_addr), 32'd0);
        chk("mid_rst_wr_data", bus.fb_wr_data, 32'd0);
        chk("mid_rst_row39", mem[39], nxt_fb[39]);
        chk("mid_rst_row41", mem[41], exp_fb[41]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gen_exp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 chk("post_rst_quiet", 32'(bus.fb_wr_en), 32'd0);
        end
        for (int r = 0; r < 75; r++) exp_fb[r] = mem[r];
        do_step(1'b0, 1'b0);
        chk_frame("post_rst_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
